// File: rtl/instruction_unit.sv
// instruction_unit: fetches one instruction word per FETCH_go through a
// request/acknowledge handshake. It holds the PC and the instruction register,
// decodes the register-address and immediate fields, and loads the PC from
// PC_in, the branch target, the jump target or RESET_PC.
// Optional feature: define IU_FETCH_TIMEOUT_EN to abandon a fetch after
// TIMEOUT_CYC request cycles without an acknowledge and set a sticky flag.
module instruction_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_go_i,
  input  logic        pc_ld_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [31:0] pc_in_i,
  input  logic [31:0] im_rdata_i,
  input  logic        im_ack_i,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] pc_out_o,
  output logic [31:0] ir_out_o,
  output logic [31:0] se_16_o,
  output logic [4:0]  s_addr_o,
  output logic [4:0]  t_addr_o,
  output logic [4:0]  d_addr_o,
  output logic        ir_valid_o,
  output logic        busy_o,
  output logic        im_timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] im_addr_q;
  logic        im_req_q;
  logic        ir_valid_q;
  logic [31:0] pc_ld_d;

`ifdef IU_FETCH_TIMEOUT_EN
  logic [7:0]  cnt_q;
  logic        timeout_q;
`endif

  // Immediate and register fields are pure wiring off the instruction register.
  assign se_16_o  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign s_addr_o = ir_q[25:21];
  assign t_addr_o = ir_q[20:16];
  assign d_addr_o = ir_q[15:11];

  // Candidate PC value for a load; the branch offset is relative to the
  // already-incremented PC.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves pc_ld_d unassigned (no latch).
    pc_ld_d = RESET_PC;
    case (pc_sel_i)
      2'b00:   pc_ld_d = pc_in_i;
      2'b01:   pc_ld_d = pc_q + {se_16_o[29:0], 2'b00};
      2'b10:   pc_ld_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: pc_ld_d = RESET_PC;
    endcase
  end

  // Fetch FSM with registered outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      im_addr_q  <= 32'h0;
      im_req_q   <= 1'b0;
      ir_valid_q <= 1'b0;
`ifdef IU_FETCH_TIMEOUT_EN
      cnt_q      <= 8'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // A PC load outranks a fetch request issued in the same cycle.
          if (pc_ld_i) begin
            pc_q <= pc_ld_d;
          end else if (fetch_go_i) begin
            state_q   <= REQ;
            im_addr_q <= pc_q;
            im_req_q  <= 1'b1;
`ifdef IU_FETCH_TIMEOUT_EN
            cnt_q     <= 8'd0;
`endif
          end
        end
        REQ: begin
          // An acknowledge in the timeout cycle still completes the fetch.
          if (im_ack_i) begin
            ir_q       <= im_rdata_i;
            pc_q       <= pc_q + 32'd4;
            im_req_q   <= 1'b0;
            ir_valid_q <= 1'b1;
            state_q    <= DONE;
          end
`ifdef IU_FETCH_TIMEOUT_EN
          else if (cnt_q == TIMEOUT_CYC - 8'd1) begin
            cnt_q     <= cnt_q + 8'd1;
            im_req_q  <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        DONE: begin
          ir_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign im_req_o   = im_req_q;
  assign im_addr_o  = im_addr_q;
  assign pc_out_o   = pc_q;
  assign ir_out_o   = ir_q;
  assign ir_valid_o = ir_valid_q;
  assign busy_o     = (state_q != IDLE);

`ifdef IU_FETCH_TIMEOUT_EN
  assign im_timeout_o = timeout_q;
`else
  assign im_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_unit.sv
// tb_instruction_unit: randomized fetch / PC-load / stray-acknowledge traffic
// checked against a transaction-level model of the PC and instruction register.
module tb_instruction_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [7:0]  T_CYC  = 8'd16;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_go, pc_ld, im_ack;
  logic [1:0]  pc_sel;
  logic [31:0] pc_in, im_rdata;
  logic        im_req, ir_valid, busy, im_timeout;
  logic [31:0] im_addr, pc_out, ir_out, se_16;
  logic [4:0]  s_addr, t_addr, d_addr;

  always #5 clk = ~clk;

  instruction_unit #(
    .RESET_PC    (RST_PC),
    .TIMEOUT_CYC (T_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_go_i   (fetch_go),
    .pc_ld_i      (pc_ld),
    .pc_sel_i     (pc_sel),
    .pc_in_i      (pc_in),
    .im_rdata_i   (im_rdata),
    .im_ack_i     (im_ack),
    .im_req_o     (im_req),
    .im_addr_o    (im_addr),
    .pc_out_o     (pc_out),
    .ir_out_o     (ir_out),
    .se_16_o      (se_16),
    .s_addr_o     (s_addr),
    .t_addr_o     (t_addr),
    .d_addr_o     (d_addr),
    .ir_valid_o   (ir_valid),
    .busy_o       (busy),
    .im_timeout_o (im_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC, instruction register, sticky flag.
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic        m_timeout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_go = 1'b0;
    pc_ld    = 1'b0;
    pc_sel   = 2'b00;
    pc_in    = 32'h0;
    im_ack   = 1'b0;
    im_rdata = $urandom;
  endtask

  function automatic logic [31:0] pc_target(input logic [1:0] sel, input logic [31:0] pcin);
    int off;
    off = $signed(m_ir[15:0]);
    case (sel)
      2'd0:    return pcin;
      2'd1:    return m_pc + 32'(off * 4);
      2'd2:    return (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
      default: return RST_PC;
    endcase
  endfunction

  task automatic check_fields(input string tag);
    int imm;
    imm = $signed(m_ir[15:0]);
    check({tag, "_se16"}, se_16, 32'(imm));
    check({tag, "_s"}, 32'(s_addr), (m_ir >> 21) & 32'd31);
    check({tag, "_t"}, 32'(t_addr), (m_ir >> 16) & 32'd31);
    check({tag, "_d"}, 32'(d_addr), (m_ir >> 11) & 32'd31);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    fetch_go = 1'b1;
    pc_ld    = 1'b1;
    pc_sel   = 2'b00;
    pc_in    = 32'hDEAD_BEEF;
    im_ack   = 1'b1;
    step();
    idle_inputs();
    step();
    reset     = 1'b0;
    m_pc      = RST_PC;
    m_ir      = 32'h0;
    m_timeout = 1'b0;
    check("rst_pc", pc_out, RST_PC);
    check("rst_ir", ir_out, 32'h0);
    check("rst_addr", im_addr, 32'h0);
    check("rst_ctl", 32'({im_req, ir_valid, busy, im_timeout}), 32'h0);
  endtask

  // Complete fetch: wait_n request cycles without acknowledge, then acknowledge.
  task automatic do_fetch(input int wait_n, input logic [31:0] data, input bit noise);
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    check("req_start", 32'({busy, im_req, ir_valid}), 32'b110);
    check("req_addr", im_addr, m_pc);
    for (int i = 0; i < wait_n; i++) begin
      if (noise) begin
        pc_ld    = $urandom;
        pc_sel   = $urandom;
        pc_in    = $urandom;
        fetch_go = $urandom;
      end
      im_rdata = $urandom;
      step();
      check("req_hold", 32'({busy, im_req, ir_valid}), 32'b110);
      check("req_addr_stable", im_addr, m_pc);
      check("req_ir_kept", ir_out, m_ir);
    end
    im_ack   = 1'b1;
    im_rdata = data;
    step();
    m_ir = data;
    m_pc = m_pc + 32'd4;
    idle_inputs();
    check("done_ctl", 32'({ir_valid, busy, im_req}), 32'b110);
    check("done_ir", ir_out, m_ir);
    check("done_pc", pc_out, m_pc);
    check_fields("done");
    step();
    check("after_done", 32'({ir_valid, busy, im_req}), 32'b000);
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [31:0] pcin, input logic go);
    logic [31:0] exp_pc;
    exp_pc   = pc_target(sel, pcin);
    pc_ld    = 1'b1;
    pc_sel   = sel;
    pc_in    = pcin;
    fetch_go = go;
    step();
    idle_inputs();
    m_pc = exp_pc;
    check("load_pc", pc_out, m_pc);
    check("load_no_fetch", 32'({busy, im_req}), 32'b00);
  endtask

  task automatic stray_ack();
    im_ack   = 1'b1;
    im_rdata = $urandom;
    step();
    idle_inputs();
    check("stray_ir", ir_out, m_ir);
    check("stray_ctl", 32'({ir_valid, busy, im_req}), 32'b000);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    do_reset();

    // Fetch with acknowledge three cycles after FETCH_go.
    do_fetch(2, 32'h2008_FFFC, 1'b0);
    check("ex1_pc", pc_out, 32'h0000_0004);
    check("ex1_se", se_16, 32'hFFFF_FFFC);
    check("ex1_t", 32'(t_addr), 32'd8);

    // Branch relative to the incremented PC.
    do_load(2'b01, 32'h1234_5678, 1'b0);
    check("ex2_branch", pc_out, 32'hFFFF_FFF4);

    // Jump keeps the top nibble of the PC.
    do_load(2'b00, 32'h1000_0000, 1'b0);
    do_fetch(0, 32'h0800_0010, 1'b0);
    do_load(2'b10, 32'h0, 1'b1);
    check("ex3_jump", pc_out, 32'h1000_0040);

    // Load and fetch request together in IDLE: only the load happens.
    do_load(2'b11, 32'h0, 1'b1);

    // Load/fetch requests during REQ are ignored.
    do_fetch(3, $urandom, 1'b1);

    // PC increment wraps silently.
    do_load(2'b00, 32'hFFFF_FFFC, 1'b0);
    do_fetch(1, $urandom, 1'b0);
    check("wrap_pc", pc_out, 32'h0);

    // Reset in the middle of a fetch; the late acknowledge is ignored.
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    m_pc     = RST_PC;
    m_ir     = 32'h0;
    m_timeout = 1'b0;
    im_ack   = 1'b1;
    im_rdata = 32'hCAFE_F00D;
    step();
    idle_inputs();
    check("abort_ir", ir_out, 32'h0);
    check("abort_pc", pc_out, RST_PC);
    check("abort_ctl", 32'({ir_valid, busy, im_req}), 32'b000);
    step();
    check("abort_no_valid", 32'(ir_valid), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0, 1: do_fetch(int'($urandom_range(0, 5)), $urandom, 1'($urandom));
        2:    do_load(2'($urandom), $urandom, 1'($urandom));
        default: stray_ack();
      endcase
    end

`ifdef IU_FETCH_TIMEOUT_EN
    // Abandon after T_CYC request cycles with no acknowledge.
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    for (int i = 0; i < int'(T_CYC) - 1; i++) step();
    check("to_still_req", 32'({im_req, im_timeout}), 32'b10);
    step();
    m_timeout = 1'b1;
    check("to_ctl", 32'({im_req, busy, im_timeout}), 32'b001);
    check("to_pc", pc_out, m_pc);
    check("to_ir", ir_out, m_ir);
    // Acknowledge in the timeout cycle completes normally; flag stays set.
    do_fetch(int'(T_CYC) - 1, $urandom, 1'b0);
`else
    // Without the timeout feature a long wait still completes.
    do_fetch(40, $urandom, 1'b0);
`endif
    check("timeout_flag", 32'(im_timeout), 32'(m_timeout));
    check("final_pc", pc_out, m_pc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_unit.md
INSTRUCTION_UNIT -- requirements
Module: instruction_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset and on PC_sel=11.
REQ-002 Parameter TIMEOUT_CYC, default 8'd255, maximum fetch wait cycles when the timeout feature is compiled in.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 FETCH_go  in  1  start an instruction fetch at the current PC.
REQ-006 PC_ld  in  1  load PC from the source chosen by PC_sel.
REQ-007 PC_sel  in  2  PC source: 00 PC_in, 01 branch target, 10 jump target, 11 RESET_PC.
REQ-008 PC_in  in  32  register-jump target, driven by the datapath ALU_OUT.
REQ-009 IM_rdata  in  32  instruction word from instruction memory.
REQ-010 IM_ack  in  1  instruction memory data-valid strobe.
REQ-011 IM_req  out  1  instruction memory request.
REQ-012 IM_addr  out  32  instruction memory byte address.
REQ-013 PC_out  out  32  current PC, feeding the datapath PC_in port.
REQ-014 IR_out  out  32  instruction register.
REQ-015 SE_16  out  32  sign-extended IR_out[15:0], feeding the datapath DT/DY ports.
REQ-016 S_Addr, T_Addr, D_Addr  out  5 each  IR_out[25:21], [20:16], [15:11].
REQ-017 IR_valid  out  1  one-cycle pulse when IR_out has been updated.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 IM_timeout  out  1  sticky fetch-timeout flag.

Function
REQ-020 FSM states: IDLE, REQ, DONE; busy = (state != IDLE).
REQ-021 IDLE with FETCH_go=1 -> REQ next cycle; IM_addr <= PC_out; IM_req <= 1.
REQ-022 REQ holds IM_req=1 and a stable IM_addr until IM_ack=1.
REQ-023 REQ with IM_ack=1: IR_out <= IM_rdata, PC_out <= PC_out + 4, IM_req <= 0, -> DONE.
REQ-024 DONE lasts exactly one cycle with IR_valid=1, then -> IDLE; FETCH_go-to-IR_valid latency = 2 cycles plus the IM_ack wait.
REQ-025 IM_ack outside REQ is ignored.
REQ-026 FETCH_go outside IDLE is ignored.
REQ-027 PC_ld is honoured only in IDLE; outside IDLE it is ignored.
REQ-028 PC_ld and FETCH_go together in IDLE: PC load takes effect, fetch is not started.
REQ-029 Branch target = PC_out + {SE_16[29:0], 2'b00}, modulo 2^32; PC_out is already post-increment.
REQ-030 Jump target = {PC_out[31:28], IR_out[25:0], 2'b00}.
REQ-031 PC_out + 4 wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
REQ-032 SE_16, S_Addr, T_Addr and D_Addr are combinational from IR_out.

Reset
REQ-033 Reset forces: state IDLE, PC_out = RESET_PC, IR_out = 0, IM_addr = 0, IM_req = 0, IR_valid = 0, IM_timeout = 0, timeout counter = 0.
REQ-034 Reset in REQ aborts the fetch; a later IM_ack is ignored under REQ-025.
REQ-035 Reset has priority over every other input in the same cycle.

Configuration
REQ-036 Macro IU_FETCH_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to REQ and increments each REQ cycle without IM_ack.
- When the count reaches TIMEOUT_CYC without IM_ack: IM_req <= 0, state <= IDLE, IM_timeout <= 1 (sticky until reset), IR_out and PC_out unchanged.
- IM_ack arriving in the same cycle as the timeout wins; the fetch completes normally.
REQ-037 Without IU_FETCH_TIMEOUT_EN: no counter; REQ waits indefinitely; IM_timeout is tied to 0.

Verification
REQ-038 Reset, then FETCH_go with IM_ack 3 cycles later and IM_rdata=32'h2008_FFFC -> IR_out=32'h2008_FFFC, PC_out=4, SE_16=32'hFFFF_FFFC, T_Addr=8, one IR_valid pulse.
REQ-039 After REQ-038, PC_ld with PC_sel=01 -> PC_out = 4 + 32'hFFFF_FFF0 = 32'hFFFF_FFF4.
REQ-040 PC_out=32'h1000_0004, IR_out=32'h0800_0010, PC_ld with PC_sel=10 -> PC_out=32'h1000_0040.
REQ-041 PC_ld and FETCH_go asserted during REQ -> both ignored; PC_out and IR_out change only by the ack-driven fetch.
REQ-042 Reset asserted mid-REQ, IM_ack one cycle later -> IR_out=0, PC_out=RESET_PC, IR_valid never pulses.
REQ-043 With IU_FETCH_TIMEOUT_EN and no IM_ack -> IM_timeout=1 and IM_req=0 after TIMEOUT_CYC REQ cycles; PC_out unchanged.
